coin_acceptor: RTL and testbench

Front-end stage of the vending machine that turns the three raw coin-mechanism sensor lines into clean, single-cycle, one-hot coin pulses (`rupee1`, `rupee2`, `rupee5`) for the vending FSM directly downstream. Each line is synchronised and debounced, then edge-detected. Coins are queued in a small FIFO and released one at a time with a guaranteed idle gap. Coins the machine cannot take are flagged with `reject` so the mechanism returns them.

---
 rtl/vending_pkg.sv | 31 +++
 rtl/coin_acceptor_if.sv | 23 ++
 rtl/coin_debounce.sv | 47 ++++
 rtl/coin_acceptor.sv | 119 +++++++++++
 tb/tb_coin_acceptor.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared vending-machine types: coin codes, coin values, coin_acceptor output FSM states, price.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_1 = 2'd0,
    COIN_2 = 2'd1,
    COIN_5 = 2'd2
  } coin_t;

  localparam int unsigned COIN_VAL_1 = 1;
  localparam int unsigned COIN_VAL_2 = 2;
  localparam int unsigned COIN_VAL_5 = 5;

  localparam int unsigned PRICE = 10;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } out_state_t;

  // Caller guarantees at most one bit set.
  function automatic coin_t coin_from_onehot(input logic [2:0] ev);
    coin_t c;
    c = COIN_1;
    if (ev[1]) c = COIN_2;
    if (ev[2]) c = COIN_5;
    return c;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin sensor inputs, downstream ready and coin pulse / status outputs of coin_acceptor.
interface coin_acceptor_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  logic [2:0]                  coin_raw;
  logic                        accept_en;
  logic                        rupee1;
  logic                        rupee2;
  logic                        rupee5;
  logic                        reject;
  logic [$clog2(FIFO_DEPTH):0] pending;
  logic                        fifo_full;

  modport master (
    output coin_raw, accept_en,
    input  rupee1, rupee2, rupee5, reject, pending, fifo_full
  );

  modport slave (
    input  coin_raw, accept_en,
    output rupee1, rupee2, rupee5, reject, pending, fifo_full
  );
endinterface

// File: rtl/coin_debounce.sv
// One coin sensor channel: 2-flop synchroniser, stability counter, registered rise pulse.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic [3:0] cnt_q, cnt_d;

  // Once the counter holds the limit, the level flips on the next edge regardless of the sample.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (cnt_q == DB_LIMIT) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
    end else if (sync2_q != level_q) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/coin_acceptor.sv
// Debounced coin events arbitrated into a small FIFO, released as spaced one-cycle coin pulses.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic            clk,
  input logic            reset_n,
  coin_acceptor_if.slave bus
);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [2:0]    ev;
  coin_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  out_state_t    state_q, state_d;
  coin_t         coin_q, coin_d;
  logic [3:0]    gap_q, gap_d;
  logic          rupee1_q, rupee1_d, rupee2_q, rupee2_d, rupee5_q, rupee5_d;
  logic          reject_q, reject_d;
  logic          full, empty, push, pop;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (bus.coin_raw[i]),
      .rise   (ev[i])
    );
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    full     = (count_q == DEPTH_CNT);
    empty    = (count_q == '0);
    pop      = (state_q == IDLE) && !empty && bus.accept_en;
    push     = $onehot(ev) && bus.accept_en && (!full || pop);
    reject_d = (ev != '0) && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    gap_d    = gap_q;
    rupee1_d = 1'b0;
    rupee2_d = 1'b0;
    rupee5_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          coin_d  = mem_q[rd_ptr_q];
          state_d = PULSE;
        end
      end
      PULSE: begin
        rupee1_d = (coin_q == COIN_1);
        rupee2_d = (coin_q == COIN_2);
        rupee5_d = (coin_q == COIN_5);
        gap_d    = '0;
        state_d  = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= coin_from_onehot(ev);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      coin_q   <= COIN_1;
      gap_q    <= '0;
      rupee1_q <= 1'b0;
      rupee2_q <= 1'b0;
      rupee5_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      coin_q   <= coin_d;
      gap_q    <= gap_d;
      rupee1_q <= rupee1_d;
      rupee2_q <= rupee2_d;
      rupee5_q <= rupee5_d;
      reject_q <= reject_d;
    end
  end

  assign bus.rupee1    = rupee1_q;
  assign bus.rupee2    = rupee2_q;
  assign bus.rupee5    = rupee5_q;
  assign bus.reject    = reject_q;
  assign bus.pending   = count_q;
  assign bus.fifo_full = full;
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: default instance plus a long-gap instance for FIFO-full and reset cases.
module tb_coin_acceptor;

  typedef struct {
    int kind;  // 0 rupee1, 1 rupee2, 2 rupee5, 3 reject
    int at;    // edge count after which the pulse is visible
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_g[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coin_acceptor_if #(.FIFO_DEPTH(4)) bus_a ();
  coin_acceptor_if #(.FIFO_DEPTH(4)) bus_g ();

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(15), .FIFO_DEPTH(4)) u_dut_g (
    .clk(clk), .reset_n(reset_n), .bus(bus_g)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_out(input int d, input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    if (d == 0) q_a.push_back(e);
    else        q_g.push_back(e);
  endtask

  task automatic observe(input int d, input logic [3:0] o);
    exp_t e;
    bit   none;
    if (o == 4'b0000) return;
    checks++;
    if ($countones(o[2:0]) > 1) begin
      failures++;
      $display("FAIL dut%0d_onehot: actual=%b required=at most one pulse (cyc %0d)", d, o[2:0], cyc);
    end
    for (int k = 0; k < 4; k++) begin
      if (o[k]) begin
        checks++;
        none = 1'b0;
        if (d == 0) begin
          if (q_a.size() == 0) none = 1'b1; else e = q_a.pop_front();
        end else begin
          if (q_g.size() == 0) none = 1'b1; else e = q_g.pop_front();
        end
        if (none) begin
          failures++;
          $display("FAIL dut%0d_unexpected: actual kind=%0d at cyc %0d required no output", d, k, cyc);
        end else if (e.kind != k || e.at != cyc) begin
          failures++;
          $display("FAIL dut%0d_out: actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                   d, k, cyc, e.kind, e.at);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      observe(0, {bus_a.reject, bus_a.rupee5, bus_a.rupee2, bus_a.rupee1});
      observe(1, {bus_g.reject, bus_g.rupee5, bus_g.rupee2, bus_g.rupee1});
    end
  end

  initial begin
    int c;
    bus_a.coin_raw  = 3'b000;
    bus_a.accept_en = 1'b1;
    bus_g.coin_raw  = 3'b000;
    bus_g.accept_en = 1'b1;
    reset_n = 1'b0;
    tick(3);
    chk("rst_pending_a", int'(bus_a.pending), 0);
    chk("rst_full_a", int'(bus_a.fifo_full), 0);
    chk("rst_out_a", int'({bus_a.reject, bus_a.rupee5, bus_a.rupee2, bus_a.rupee1}), 0);
    chk("rst_pending_g", int'(bus_g.pending), 0);
    reset_n = 1'b1;
    tick(2);

    // Clean 1-rupee coin held 20 cycles
    c = cyc;
    bus_a.coin_raw[0] = 1'b1;
    expect_out(0, 0, c + 10);
    tick(8);
    chk("t1_pending_push", int'(bus_a.pending), 1);
    tick(1);
    chk("t1_pending_pop", int'(bus_a.pending), 0);
    tick(11);
    bus_a.coin_raw = 3'b000;
    tick(30);

    // 3-cycle glitch on the 5-rupee line
    bus_a.coin_raw[2] = 1'b1;
    tick(3);
    bus_a.coin_raw[2] = 1'b0;
    tick(20);

    // Coins 5, 2, 1 one cycle apart
    c = cyc;
    bus_a.coin_raw[2] = 1'b1;
    expect_out(0, 2, c + 10);
    tick(1);
    bus_a.coin_raw[1] = 1'b1;
    expect_out(0, 1, c + 13);
    tick(1);
    bus_a.coin_raw[0] = 1'b1;
    expect_out(0, 0, c + 16);
    tick(8);
    chk("t3_pending_peak", int'(bus_a.pending), 2);
    tick(5);
    chk("t3_pending_drained", int'(bus_a.pending), 0);
    tick(2);
    bus_a.coin_raw = 3'b000;
    tick(30);

    // Coin while downstream not ready
    bus_a.accept_en = 1'b0;
    c = cyc;
    bus_a.coin_raw[0] = 1'b1;
    expect_out(0, 3, c + 8);
    tick(9);
    chk("t4_no_push", int'(bus_a.pending), 0);
    tick(3);
    bus_a.coin_raw = 3'b000;
    tick(20);
    bus_a.accept_en = 1'b1;
    tick(2);

    // Two coins queued behind a busy FSM, then held while accept_en is low
    c = cyc;
    bus_a.coin_raw[0] = 1'b1;
    expect_out(0, 0, c + 10);
    tick(2);
    bus_a.coin_raw[1] = 1'b1;
    expect_out(0, 1, c + 23);
    tick(1);
    bus_a.coin_raw[2] = 1'b1;
    expect_out(0, 2, c + 26);
    tick(8);
    bus_a.accept_en = 1'b0;
    chk("t4_held_start", int'(bus_a.pending), 2);
    tick(10);
    chk("t4_held_end", int'(bus_a.pending), 2);
    bus_a.accept_en = 1'b1;
    bus_a.coin_raw  = 3'b000;
    tick(30);

    // Simultaneous 1 and 2 rupee events
    c = cyc;
    bus_a.coin_raw = 3'b011;
    expect_out(0, 3, c + 8);
    tick(9);
    chk("t5_dual_no_push", int'(bus_a.pending), 0);
    tick(3);
    bus_a.coin_raw = 3'b000;
    tick(20);

    // Fill the FIFO during a 15-cycle gap, then a fifth coin
    c = cyc;
    bus_g.coin_raw[0] = 1'b1;
    expect_out(1, 0, c + 10);
    tick(3);  bus_g.coin_raw[1] = 1'b1;
    tick(1);  bus_g.coin_raw[2] = 1'b1;
    tick(1);  bus_g.coin_raw[0] = 1'b0;
    tick(3);  bus_g.coin_raw[1] = 1'b0;
    tick(1);  bus_g.coin_raw[2] = 1'b0;
    tick(2);  bus_g.coin_raw[0] = 1'b1;
    tick(5);  bus_g.coin_raw[1] = 1'b1;
    tick(1);  bus_g.coin_raw[2] = 1'b1;
    expect_out(1, 3, c + 25);
    expect_out(1, 1, c + 27);
    tick(8);
    chk("t5_full_pending", int'(bus_g.pending), 4);
    chk("t5_full_flag", int'(bus_g.fifo_full), 1);
    tick(1);
    chk("t5_after_pop_pending", int'(bus_g.pending), 3);
    chk("t5_after_pop_flag", int'(bus_g.fifo_full), 0);
    tick(4);
    bus_g.coin_raw = 3'b000;

    // Reset for one edge while the 5-rupee coin is in PULSE
    tick(13);
    chk("t6_pending_before", int'(bus_g.pending), 2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("t6_pending_after", int'(bus_g.pending), 0);
    chk("t6_full_after", int'(bus_g.fifo_full), 0);
    chk("t6_out_after", int'({bus_g.reject, bus_g.rupee5, bus_g.rupee2, bus_g.rupee1}), 0);
    tick(60);

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_g_drained", q_g.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
